rtc_timekeeper: RTL and testbench

Parametrised time-of-day core that keeps hours, minutes and seconds, plus a day count. It adds runtime time-set, a run/pause control, a 12/24-hour display mode and a sticky alarm. It sits between the board clock and the display/UI logic, and replaces the fixed 24-hour counter in new designs. One-second ticks come from an internal divider of the input clock.

---
 rtl/rtc_timekeeper_pkg.sv | 23 ++
 rtl/rtc_timekeeper_if.sv | 41 ++++
 rtl/rtc_timekeeper_tick_gen.sv | 31 +++
 rtl/rtc_timekeeper.sv | 118 +++++++++++
 tb/tb_rtc_timekeeper.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_timekeeper_pkg.sv
// Shared time-of-day widths, limits and the packed time record
// used by the timekeeper core and its bus interface.
package rtc_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } rtc_time_t;

    function automatic logic time_valid(input rtc_time_t t);
        return (t.hr <= HR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control, load, alarm and time-display signals of the timekeeper,
// with modports for the UI side (master) and the core (slave).
interface rtc_timekeeper_if #(
    parameter int DAY_W = 16
);
    import rtc_pkg::*;

    logic             run;
    logic             mode_12h;
    logic             set_valid;
    logic [HR_W-1:0]  set_hr;
    logic [MIN_W-1:0] set_min;
    logic [SEC_W-1:0] set_sec;
    logic             set_err;
    logic             alarm_en;
    logic [HR_W-1:0]  alarm_hr;
    logic [MIN_W-1:0] alarm_min;
    logic [SEC_W-1:0] alarm_sec;
    logic             alarm_ack;
    logic [SEC_W-1:0] sec;
    logic [MIN_W-1:0] min;
    logic [HR_W-1:0]  hr;
    logic [HR_W-1:0]  disp_hr;
    logic             pm;
    logic [DAY_W-1:0] day;
    logic             tick;
    logic             alarm_flag;

    modport master (
        output run, mode_12h, set_valid, set_hr, set_min, set_sec,
               alarm_en, alarm_hr, alarm_min, alarm_sec, alarm_ack,
        input  set_err, sec, min, hr, disp_hr, pm, day, tick, alarm_flag
    );

    modport slave (
        input  run, mode_12h, set_valid, set_hr, set_min, set_sec,
               alarm_en, alarm_hr, alarm_min, alarm_sec, alarm_ack,
        output set_err, sec, min, hr, disp_hr, pm, day, tick, alarm_flag
    );

endinterface

// File: rtl/rtc_timekeeper_tick_gen.sv
// One-second tick divider: counts 0..DIVIDER-1 while run is high,
// holds while paused, and can be cleared by a time load.
module rtc_tick_gen #(
    parameter int DIVIDER = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(DIVIDER - 1));
    assign tick     = run && w_at_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: hh:mm:ss plus day count, runtime load with range
// check, run/pause, 12/24-hour display mapping and a sticky alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int DIVIDER = 50_000_000,
    parameter int DAY_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    rtc_timekeeper_if.slave bus
);

    logic             w_tick;
    logic             w_set_ok;
    logic             w_load;
    logic             w_reject;
    logic             w_day_wrap;
    rtc_time_t        w_set;
    rtc_time_t        w_alarm;
    rtc_time_t        w_next;
    rtc_time_t        r_time;
    logic [DAY_W-1:0] r_day;
    logic             r_advanced;
    logic             r_alarm_flag;
    logic             r_set_err;
    logic [HR_W-1:0]  w_disp_hr;

    always_comb begin
        w_set   = '{hr: bus.set_hr,   min: bus.set_min,   sec: bus.set_sec};
        w_alarm = '{hr: bus.alarm_hr, min: bus.alarm_min, sec: bus.alarm_sec};
    end

    assign w_set_ok = time_valid(w_set);
    assign w_load   = bus.set_valid && w_set_ok;
    assign w_reject = bus.set_valid && !w_set_ok;

    rtc_tick_gen #(
        .DIVIDER (DIVIDER)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (bus.run),
        .clr   (w_load),
        .tick  (w_tick)
    );

    always_comb begin
        w_next     = r_time;
        w_day_wrap = 1'b0;
        if (r_time.sec == SEC_MAX) begin
            w_next.sec = '0;
            if (r_time.min == MIN_MAX) begin
                w_next.min = '0;
                if (r_time.hr == HR_MAX) begin
                    w_next.hr  = '0;
                    w_day_wrap = 1'b1;
                end else begin
                    w_next.hr = r_time.hr + HR_W'(1);
                end
            end else begin
                w_next.min = r_time.min + MIN_W'(1);
            end
        end else begin
            w_next.sec = r_time.sec + SEC_W'(1);
        end
    end

    // r_advanced marks a tick-driven update so the alarm compare sees the
    // new time one cycle later and loads can never raise the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time       <= '0;
            r_day        <= '0;
            r_advanced   <= 1'b0;
            r_alarm_flag <= 1'b0;
            r_set_err    <= 1'b0;
        end else begin
            r_set_err  <= w_reject;
            r_advanced <= w_tick && !w_load;
            if (w_load) begin
                r_time <= w_set;
            end else if (w_tick) begin
                r_time <= w_next;
                if (w_day_wrap) begin
                    r_day <= r_day + DAY_W'(1);
                end
            end
            if (r_advanced && bus.alarm_en && (r_time == w_alarm)) begin
                r_alarm_flag <= 1'b1;
            end else if (bus.alarm_ack) begin
                r_alarm_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_disp_hr = r_time.hr;
        if (bus.mode_12h) begin
            if (r_time.hr == '0) begin
                w_disp_hr = HR_W'(12);
            end else if (r_time.hr > HR_W'(12)) begin
                w_disp_hr = r_time.hr - HR_W'(12);
            end
        end
    end

    assign bus.sec        = r_time.sec;
    assign bus.min        = r_time.min;
    assign bus.hr         = r_time.hr;
    assign bus.disp_hr    = w_disp_hr;
    assign bus.pm         = (r_time.hr >= HR_W'(12));
    assign bus.day        = r_day;
    assign bus.tick       = w_tick;
    assign bus.alarm_flag = r_alarm_flag;
    assign bus.set_err    = r_set_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with DIVIDER=4, DAY_W=4; expected
// values are hand-derived cycle by cycle.
module tb_rtc_timekeeper;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    rtc_timekeeper_if #(.DAY_W(4)) bus ();

    rtc_timekeeper #(
        .DIVIDER (4),
        .DAY_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned h, input int unsigned m, input int unsigned s);
        bus.set_hr    = 5'(h);
        bus.set_min   = 6'(m);
        bus.set_sec   = 6'(s);
        bus.set_valid = 1'b1;
        cyc();
        bus.set_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        check("tick_seen", 32'(bus.tick), 1);
    endtask

    initial begin
        int ticks;
        n_chk          = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.run        = 1'b1;
        bus.mode_12h   = 1'b0;
        bus.set_valid  = 1'b0;
        bus.set_hr     = '0;
        bus.set_min    = '0;
        bus.set_sec    = '0;
        bus.alarm_en   = 1'b0;
        bus.alarm_hr   = '0;
        bus.alarm_min  = '0;
        bus.alarm_sec  = '0;
        bus.alarm_ack  = 1'b0;

        // Reset state and first tick
        cyc();
        cyc();
        check("rst_sec", 32'(bus.sec), 0);
        check("rst_hr", 32'(bus.hr), 0);
        check("rst_day", 32'(bus.day), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_flag", 32'(bus.alarm_flag), 0);
        check("rst_err", 32'(bus.set_err), 0);
        reset = 1'b0;
        cyc();
        cyc();
        check("first_tick_early", 32'(bus.tick), 0);
        cyc();
        check("first_tick", 32'(bus.tick), 1);
        check("sec_before_tick", 32'(bus.sec), 0);
        cyc();
        check("sec_after_tick", 32'(bus.sec), 1);
        check("tick_one_cycle", 32'(bus.tick), 0);

        // Full rollover: build day=15, then 23:59:58 -> 00:00:00, day wraps
        for (int i = 0; i < 15; i++) begin
            do_load(23, 59, 59);
            wait_tick();
            cyc();
        end
        check("day15", 32'(bus.day), 15);
        do_load(23, 59, 58);
        check("pm_at_23", 32'(bus.pm), 1);
        wait_tick();
        cyc();
        check("sec59", 32'(bus.sec), 59);
        wait_tick();
        cyc();
        check("roll_hr", 32'(bus.hr), 0);
        check("roll_min", 32'(bus.min), 0);
        check("roll_sec", 32'(bus.sec), 0);
        check("roll_day", 32'(bus.day), 0);
        check("roll_pm", 32'(bus.pm), 0);

        // Rejected load on a tick cycle: error pulse, advance still happens
        wait_tick();
        bus.set_hr    = 5'd24;
        bus.set_min   = 6'd0;
        bus.set_sec   = 6'd0;
        bus.set_valid = 1'b1;
        cyc();
        bus.set_valid = 1'b0;
        check("err_pulse", 32'(bus.set_err), 1);
        check("err_hr", 32'(bus.hr), 0);
        check("err_tick_kept", 32'(bus.sec), 1);
        cyc();
        check("err_one_cycle", 32'(bus.set_err), 0);

        // Valid load on a tick cycle: no advance, next tick DIVIDER later
        wait_tick();
        do_load(12, 30, 0);
        check("ld_hr", 32'(bus.hr), 12);
        check("ld_min", 32'(bus.min), 30);
        check("ld_sec", 32'(bus.sec), 0);
        check("ld_err", 32'(bus.set_err), 0);
        cyc();
        cyc();
        check("ld_tick_early", 32'(bus.tick), 0);
        cyc();
        check("ld_tick", 32'(bus.tick), 1);

        // 12-hour mapping
        bus.mode_12h = 1'b1;
        do_load(0, 10, 0);
        check("disp_h0", 32'(bus.disp_hr), 12);
        check("pm_h0", 32'(bus.pm), 0);
        do_load(12, 10, 0);
        check("disp_h12", 32'(bus.disp_hr), 12);
        check("pm_h12", 32'(bus.pm), 1);
        do_load(13, 10, 0);
        check("disp_h13", 32'(bus.disp_hr), 1);
        check("pm_h13", 32'(bus.pm), 1);
        bus.mode_12h = 1'b0;
        #1;
        check("disp_24h", 32'(bus.disp_hr), 13);

        // Alarm
        bus.alarm_en  = 1'b1;
        bus.alarm_sec = 6'd5;
        do_load(0, 0, 5);
        cyc();
        check("flag_no_load", 32'(bus.alarm_flag), 0);
        do_load(0, 0, 4);
        cyc();
        cyc();
        cyc();
        check("al_tick", 32'(bus.tick), 1);
        cyc();
        check("al_sec5", 32'(bus.sec), 5);
        check("flag_n1", 32'(bus.alarm_flag), 0);
        cyc();
        check("flag_n2", 32'(bus.alarm_flag), 1);
        cyc();
        cyc();
        cyc();
        check("flag_hold", 32'(bus.alarm_flag), 1);
        bus.alarm_ack = 1'b1;
        cyc();
        bus.alarm_ack = 1'b0;
        check("flag_ack", 32'(bus.alarm_flag), 0);
        do_load(0, 0, 4);
        for (int i = 0; i < 4; i++) cyc();
        check("flag_pre_race", 32'(bus.alarm_flag), 0);
        bus.alarm_ack = 1'b1;
        cyc();
        bus.alarm_ack = 1'b0;
        check("flag_set_wins", 32'(bus.alarm_flag), 1);

        // Pause holds the divider and time; resume loses no ticks
        do_load(1, 2, 3);
        cyc();
        bus.run = 1'b0;
        ticks   = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.tick === 1'b1) ticks++;
        end
        check("pause_ticks", 32'(ticks), 0);
        check("pause_sec", 32'(bus.sec), 3);
        bus.run = 1'b1;
        cyc();
        check("resume_early", 32'(bus.tick), 0);
        cyc();
        check("resume_tick", 32'(bus.tick), 1);
        cyc();
        check("resume_sec", 32'(bus.sec), 4);
        bus.run = 1'b0;
        do_load(5, 6, 7);
        check("pause_ld_hr", 32'(bus.hr), 5);
        check("pause_ld_sec", 32'(bus.sec), 7);
        check("pause_no_tick", 32'(bus.tick), 0);
        bus.run = 1'b1;

        // Asynchronous reset mid-count, while tick is high
        wait_tick();
        check("flag_before_rst", 32'(bus.alarm_flag), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", 32'(bus.tick), 0);
        check("arst_hr", 32'(bus.hr), 0);
        check("arst_min", 32'(bus.min), 0);
        check("arst_sec", 32'(bus.sec), 0);
        check("arst_flag", 32'(bus.alarm_flag), 0);
        cyc();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
